// File: rtl/fifo_byte_packer.sv
// ============================================================================
// Module   : fifo_byte_packer
// Purpose  : Read-domain consumer for a nibble-wide FIFO. Pops entries as they
//            become available, packs WORD_NIBBLES of them little-endian into
//            one word and presents it on a valid/ready port. A flush request
//            emits a pending partial word, zero-padded in its unfilled nibbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_byte_packer #(
  parameter int DATA_WIDTH   = 4,
  parameter int WORD_NIBBLES = 2,
  parameter int COUNT_WIDTH  = 8
) (
  input  logic                               read_clock,
  input  logic                               read_reset,
  input  logic                               fifo_empty,
  input  logic [DATA_WIDTH-1:0]              fifo_read_data,
  output logic                               fifo_read_increment,
  input  logic                               flush,
  output logic [DATA_WIDTH*WORD_NIBBLES-1:0] out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_partial,
  output logic [COUNT_WIDTH-1:0]             word_count
);

  localparam int WORD_WIDTH = DATA_WIDTH * WORD_NIBBLES;
  localparam int IDX_W      = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_NIBBLES - 1);

  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_WIDTH-1:0]  asm_q, asm_d;
  logic [WORD_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_partial_q, out_partial_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   flush_pending_q, flush_pending_d;

  logic                   w_free;
  logic                   w_last;
  logic                   w_pop;
  logic [WORD_WIDTH-1:0]  w_asm_ins;

  // Next-state: handshake retire first, then pop/pack, then flush handling.
  // Pops are blocked while a flush is pending, so a pop and a flush emission
  // never compete for the output slot in the same cycle.
  always_comb begin
    w_free    = !out_valid_q || out_ready;
    w_last    = (idx_q == LAST_IDX);
    w_pop     = !read_reset && !fifo_empty && !flush_pending_q && !(w_last && !w_free);
    w_asm_ins = asm_q;
    w_asm_ins[idx_q*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;

    idx_d           = idx_q;
    asm_d           = asm_q;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    out_partial_d   = out_partial_q;
    count_d         = count_q;
    flush_pending_d = flush_pending_q;

    if (out_valid_q && out_ready) begin
      count_d     = count_q + COUNT_WIDTH'(1);
      out_valid_d = 1'b0;
    end

    if (w_pop) begin
      if (w_last) begin
        out_data_d    = w_asm_ins;
        out_valid_d   = 1'b1;
        out_partial_d = 1'b0;
        idx_d         = '0;
        asm_d         = '0;
      end else begin
        asm_d = w_asm_ins;
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (flush_pending_q) begin
      if (w_free) begin
        out_data_d      = asm_q;
        out_valid_d     = 1'b1;
        out_partial_d   = 1'b1;
        idx_d           = '0;
        asm_d           = '0;
        flush_pending_d = 1'b0;
      end
    end else if (flush && (idx_d != '0)) begin
      flush_pending_d = 1'b1;
    end
  end

  // State registers with synchronous reset; reset discards any partial word.
  always_ff @(posedge read_clock) begin
    if (read_reset) begin
      idx_q           <= '0;
      asm_q           <= '0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      out_partial_q   <= 1'b0;
      count_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      asm_q           <= asm_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      out_partial_q   <= out_partial_d;
      count_q         <= count_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign fifo_read_increment = w_pop;
  assign out_data            = out_data_q;
  assign out_valid           = out_valid_q;
  assign out_partial         = out_partial_q;
  assign word_count          = count_q;

endmodule

`default_nettype wire
